usb2_in_arbiter: RTL and testbench

- Shares the single external IN endpoint buffer of the USB 2.0 core between NUM_REQ byte-stream requesters on the ext_clk side.
- Round-robin grants one requester at a time, writes its bytes into buffer addresses 0..n-1, commits with length, waits for commit_ack, then waits for buf_in_ready before the next grant.
- Sits between application data sources and the core's buf_in_* interface.

---
 rtl/usb2_arb_pkg.sv | 22 ++
 rtl/usb2_rr_pick.sv | 37 +++
 rtl/usb2_in_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_usb2_in_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb2_arb_pkg.sv
// ============================================================================
// usb2_arb_pkg : shared widths, defaults and FSM state type for the IN arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package usb2_arb_pkg;

    localparam int ADDR_W          = 9;
    localparam int LEN_W           = 10;
    localparam int DEFAULT_MAX_PKT = 512;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_RDY = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/usb2_rr_pick.sv
// ============================================================================
// usb2_rr_pick : first set request at or after the pointer, wrapping, one-hot
// Rev 1.0
// ============================================================================
`default_nettype none

module usb2_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             found
);

    // First pass scans ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb2_in_arbiter.sv
// ============================================================================
// usb2_in_arbiter : round-robin owner of the core's single IN endpoint buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module usb2_in_arbiter
    import usb2_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_PKT     = DEFAULT_MAX_PKT,
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic                   ext_clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [ADDR_W-1:0]      buf_in_addr,
    output logic [7:0]             buf_in_data,
    output logic                   buf_in_wren,
    input  logic                   buf_in_ready,
    output logic                   buf_in_commit,
    output logic [LEN_W-1:0]       buf_in_commit_len,
    input  logic                   buf_in_commit_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   err_commit_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic                ready_s1, ready_s2;
    logic                ack_s1, ack_s2;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic [LEN_W-1:0]    count;
    logic [TO_W-1:0]     to_cnt;
    logic                truncated;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic                pick_found;
    logic [7:0]          sel_data;
    logic                sel_last;
    logic                start;
    logic                accept;
    logic                pkt_end;
    logic                timeout;
    logic                release_pkt;
    logic                resume;

    usb2_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    // Core-domain handshakes are double-flopped before any use.
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_s1 <= 1'b0;
            ready_s2 <= 1'b0;
            ack_s1   <= 1'b0;
            ack_s2   <= 1'b0;
        end else begin
            ready_s1 <= buf_in_ready;
            ready_s2 <= ready_s1;
            ack_s1   <= buf_in_commit_ack;
            ack_s2   <= ack_s1;
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign req_ready = (state == ST_XFER) ? grant : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        accept      = 1'b0;
        pkt_end     = 1'b0;
        timeout     = 1'b0;
        release_pkt = 1'b0;
        resume      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ready_s2 && !ack_s2 && pick_found) begin
                    start     = 1'b1;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                accept = |(req_valid & grant);
                if (accept && (sel_last || (count == LEN_W'(MAX_PKT - 1)))) begin
                    pkt_end   = 1'b1;
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (ack_s2) begin
                    state_nxt = ST_WAIT_RDY;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (!ack_s2 && ready_s2) begin
                    if (truncated) begin
                        resume    = 1'b1;
                        state_nxt = ST_XFER;
                    end else begin
                        release_pkt = 1'b1;
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            grant              <= '0;
            rr_ptr             <= '0;
            count              <= '0;
            to_cnt             <= '0;
            truncated          <= 1'b0;
            buf_in_addr        <= '0;
            buf_in_data        <= '0;
            buf_in_wren        <= 1'b0;
            buf_in_commit      <= 1'b0;
            buf_in_commit_len  <= '0;
            err_commit_timeout <= 1'b0;
        end else begin
            buf_in_wren        <= accept;
            err_commit_timeout <= timeout;
            if (start) begin
                grant <= pick_gnt;
                count <= '0;
            end
            if (accept) begin
                buf_in_addr <= count[ADDR_W-1:0];
                buf_in_data <= sel_data;
                count       <= count + LEN_W'(1);
            end
            if (resume) begin
                count <= '0;
            end
            // A packet cut at MAX_PKT without req_last continues under the same grant.
            if (pkt_end) begin
                buf_in_commit     <= 1'b1;
                buf_in_commit_len <= count + LEN_W'(1);
                truncated         <= !sel_last;
                to_cnt            <= '0;
            end
            if (state == ST_COMMIT) begin
                if (ack_s2 || timeout) begin
                    buf_in_commit <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
            if (timeout || release_pkt) begin
                grant  <= '0;
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb2_in_arbiter.sv
// ============================================================================
// tb_usb2_in_arbiter : directed packets against a packet-level arbitration model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_usb2_in_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int MAX_PKT     = 512;
    localparam int ACK_TIMEOUT = 30;

    logic        ext_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [8:0]  buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [9:0]  buf_in_commit_len;
    logic        buf_in_commit_ack;
    logic [1:0]  grant;
    logic        busy;
    logic        err_commit_timeout;

    always #5 ext_clk = ~ext_clk;

    usb2_in_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MAX_PKT     (MAX_PKT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .ext_clk            (ext_clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_last           (req_last),
        .req_ready          (req_ready),
        .buf_in_addr        (buf_in_addr),
        .buf_in_data        (buf_in_data),
        .buf_in_wren        (buf_in_wren),
        .buf_in_ready       (buf_in_ready),
        .buf_in_commit      (buf_in_commit),
        .buf_in_commit_len  (buf_in_commit_len),
        .buf_in_commit_ack  (buf_in_commit_ack),
        .grant              (grant),
        .busy               (busy),
        .err_commit_timeout (err_commit_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] src0[$], src1[$];
    logic [8:0] exp0[$], exp1[$];
    int exp_grant_q[$];
    int exp_len_q[$];
    int grant_log[$];
    int len_log[$];
    int wr_cnt = 0;
    int err_cnt = 0;
    int last_commit_hi = 0;

    bit ack_en     = 1'b1;
    bit hold_ready = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Each byte carries {last, data}; the same stream feeds the driver and the model.
    task automatic load_pkt(int r, int len, int base, int step);
        logic [8:0] b;
        for (int k = 0; k < len; k++) begin
            b = {(k == len - 1), 8'(base + k * step)};
            if (r == 0) begin src0.push_back(b); exp0.push_back(b); end
            else        begin src1.push_back(b); exp1.push_back(b); end
        end
    endtask

    // Packet-level round robin: each packet is one grant, pointer moves past the owner.
    task automatic plan_grants(int n0, int n1);
        int cnt[NUM_REQ];
        int p;
        int pick;
        cnt[0] = n0;
        cnt[1] = n1;
        p = 0;
        while (cnt[0] + cnt[1] > 0) begin
            pick = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pick < 0 && cnt[(p + k) % NUM_REQ] > 0) pick = (p + k) % NUM_REQ;
            end
            exp_grant_q.push_back(pick);
            cnt[pick]--;
            p = (pick + 1) % NUM_REQ;
        end
    endtask

    function automatic bit quiet();
        return src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 &&
               exp1.size() == 0 && exp_grant_q.size() == 0 && exp_len_q.size() == 0 &&
               !busy && buf_in_ready && !buf_in_commit_ack;
    endfunction

    task automatic wait_done(string name, int budget);
        int c;
        c = 0;
        while (!quiet() && c < budget) begin
            @(negedge ext_clk);
            c++;
        end
        check(name, 32'(c < budget), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge ext_clk);
        reset_n = 1'b0;
        src0.delete();
        src1.delete();
        #1;
        check("rst_ctl", {grant, req_ready, busy, buf_in_wren, buf_in_commit, err_commit_timeout}, 32'd0);
        check("rst_data", {buf_in_addr, buf_in_data, buf_in_commit_len}, 32'd0);
        repeat (3) @(negedge ext_clk);
        reset_n = 1'b1;
    endtask

    // Requester drivers: pop a byte once it was accepted at the preceding edge.
    initial begin
        logic [1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge ext_clk);
            acc = req_valid & req_ready;
            @(posedge ext_clk);
            #1;
            if (acc[0] && src0.size() > 0) void'(src0.pop_front());
            if (acc[1] && src1.size() > 0) void'(src1.pop_front());
            if (src0.size() > 0) begin
                req_valid[0] = 1'b1; req_data[7:0] = src0[0][7:0]; req_last[0] = src0[0][8];
            end else begin
                req_valid[0] = 1'b0; req_last[0] = 1'b0;
            end
            if (src1.size() > 0) begin
                req_valid[1] = 1'b1; req_data[15:8] = src1[0][7:0]; req_last[1] = src1[0][8];
            end else begin
                req_valid[1] = 1'b0; req_last[1] = 1'b0;
            end
        end
    end

    // Core model: ack two cycles after commit (ready drops with it), ready returns later.
    initial begin
        logic core_ready;
        int   ack_dly;
        int   rdy_dly;
        core_ready        = 1'b1;
        ack_dly           = 0;
        rdy_dly           = 0;
        buf_in_ready      = 1'b1;
        buf_in_commit_ack = 1'b0;
        forever begin
            @(posedge ext_clk);
            #1;
            if (buf_in_commit && ack_en && !buf_in_commit_ack) begin
                ack_dly++;
                if (ack_dly >= 2) begin
                    buf_in_commit_ack = 1'b1;
                    core_ready        = 1'b0;
                    ack_dly           = 0;
                end
            end else begin
                ack_dly = 0;
            end
            if (!buf_in_commit && buf_in_commit_ack) begin
                buf_in_commit_ack = 1'b0;
                rdy_dly           = 3;
            end else if (rdy_dly > 0) begin
                rdy_dly--;
                if (rdy_dly == 0) core_ready = 1'b1;
            end
            buf_in_ready = core_ready & !hold_ready;
        end
    end

    // Compare process: every cycle against the stream/packet model.
    initial begin
        int         owner;
        int         off;
        int         hi_cnt;
        int         e;
        logic [1:0] pg;
        logic       pc;
        logic       pe;
        logic [9:0] held_len;
        logic [8:0] b;
        bit         have;
        owner = 0; off = 0; hi_cnt = 0; pg = '0; pc = 1'b0; pe = 1'b0; held_len = '0;
        forever begin
            @(negedge ext_clk);
            if (!reset_n) begin
                exp0.delete(); exp1.delete(); exp_grant_q.delete(); exp_len_q.delete();
                grant_log.delete(); len_log.delete();
                owner = 0; off = 0; hi_cnt = 0; pg = '0; pc = 1'b0; pe = 1'b0;
                wr_cnt = 0; err_cnt = 0;
            end else begin
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                check("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
                if (grant != 2'b00 && pg == 2'b00) begin
                    grant_log.push_back(int'(grant));
                    if (exp_grant_q.size() == 0) begin
                        check("grant_unexpected", 32'(grant), 32'd0);
                    end else begin
                        e = exp_grant_q.pop_front();
                        check("grant", 32'(grant), 32'(1 << e));
                        owner = e;
                        off   = 0;
                    end
                end
                if (buf_in_wren) begin
                    wr_cnt++;
                    check("wren_owner", 32'(grant != 2'b00), 32'd1);
                    have = 1'b0;
                    b    = '0;
                    if (owner == 0 && exp0.size() > 0) begin b = exp0.pop_front(); have = 1'b1; end
                    if (owner == 1 && exp1.size() > 0) begin b = exp1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        check("wr_unexpected", 32'(buf_in_wren), 32'd0);
                    end else begin
                        check("wr_addr", 32'(buf_in_addr), 32'(off));
                        check("wr_data", 32'(buf_in_data), 32'(b[7:0]));
                        off++;
                        if (b[8] || off == MAX_PKT) begin
                            exp_len_q.push_back(off);
                            off = 0;
                        end
                    end
                end
                if (buf_in_commit && !pc) begin
                    len_log.push_back(int'(buf_in_commit_len));
                    held_len = buf_in_commit_len;
                    hi_cnt   = 0;
                    if (exp_len_q.size() == 0) begin
                        check("commit_unexpected", 32'(buf_in_commit), 32'd0);
                    end else begin
                        e = exp_len_q.pop_front();
                        check("commit_len", 32'(buf_in_commit_len), 32'(e));
                    end
                end
                if (buf_in_commit) begin
                    hi_cnt++;
                    if (pc) check("commit_len_stable", 32'(buf_in_commit_len), 32'(held_len));
                end
                if (!buf_in_commit && pc) last_commit_hi = hi_cnt;
                if (err_commit_timeout) begin
                    err_cnt++;
                    if (pe) check("err_pulse_width", 32'(err_commit_timeout), 32'd0);
                end
                pg = grant;
                pc = buf_in_commit;
                pe = err_commit_timeout;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Single requester, AA BB CC DD.
        do_reset();
        load_pkt(0, 4, 'hAA, 'h11);
        plan_grants(1, 0);
        wait_done("t1_done", 200);
        check("t1_len_count", 32'(len_log.size()), 32'd1);
        if (len_log.size() > 0) check("t1_len", 32'(len_log[0]), 32'd4);
        check("t1_wr_count", 32'(wr_cnt), 32'd4);
        check("t1_grant_end", 32'(grant), 32'd0);

        // Alternating 2-byte packets from both requesters.
        do_reset();
        load_pkt(0, 2, 'h01, 1); load_pkt(0, 2, 'h11, 1);
        load_pkt(1, 2, 'h81, 1); load_pkt(1, 2, 'h91, 1);
        plan_grants(2, 2);
        wait_done("t2_done", 400);
        check("t2_grants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("t2_g0", 32'(grant_log[0]), 32'd1);
            check("t2_g1", 32'(grant_log[1]), 32'd2);
            check("t2_g2", 32'(grant_log[2]), 32'd1);
            check("t2_g3", 32'(grant_log[3]), 32'd2);
        end

        // 600-byte packet split at MAX_PKT under one grant.
        do_reset();
        load_pkt(0, 600, 0, 1);
        plan_grants(1, 0);
        wait_done("t3_done", 2000);
        check("t3_len_count", 32'(len_log.size()), 32'd2);
        if (len_log.size() == 2) begin
            check("t3_len0", 32'(len_log[0]), 32'd512);
            check("t3_len1", 32'(len_log[1]), 32'd88);
        end
        check("t3_one_grant", 32'(grant_log.size()), 32'd1);
        check("t3_wr_count", 32'(wr_cnt), 32'd600);

        // Core never acks the first commit.
        do_reset();
        ack_en = 1'b0;
        load_pkt(0, 2, 'h30, 1);
        load_pkt(1, 2, 'h50, 1);
        plan_grants(1, 1);
        c = 0;
        while (!err_commit_timeout && c < 300) begin
            @(negedge ext_clk);
            c++;
        end
        check("t4_err_seen", 32'(err_commit_timeout), 32'd1);
        check("t4_commit_dropped", 32'(buf_in_commit), 32'd0);
        check("t4_grant_cleared", 32'(grant), 32'd0);
        @(negedge ext_clk);
        check("t4_commit_cycles", 32'(last_commit_hi), 32'(ACK_TIMEOUT + 1));
        ack_en = 1'b1;
        wait_done("t4_done", 400);
        check("t4_err_count", 32'(err_cnt), 32'd1);
        if (grant_log.size() == 2) check("t4_next_grant", 32'(grant_log[1]), 32'd2);
        else check("t4_grant_count", 32'(grant_log.size()), 32'd2);

        // No grant while the core buffer is busy; grant 3 cycles after ready rises.
        hold_ready = 1'b1;
        do_reset();
        load_pkt(0, 1, 'h77, 1);
        plan_grants(1, 0);
        repeat (8) begin
            @(negedge ext_clk);
            check("t5_no_grant", 32'({grant, busy}), 32'd0);
        end
        hold_ready = 1'b0;
        @(posedge ext_clk);
        repeat (3) @(negedge ext_clk);
        check("t5_grant_lat2", 32'(grant), 32'd0);
        @(negedge ext_clk);
        check("t5_grant_lat3", 32'(grant), 32'd1);
        wait_done("t5_done", 200);

        // Reset in the middle of a transfer.
        do_reset();
        load_pkt(0, 8, 'h10, 1);
        plan_grants(1, 0);
        c = 0;
        while (wr_cnt < 3 && c < 100) begin
            @(negedge ext_clk);
            c++;
        end
        check("t6_mid_xfer", 32'({busy, buf_in_commit}), 32'd2);
        do_reset();
        repeat (10) @(negedge ext_clk);
        check("t6_no_commit", 32'(len_log.size()), 32'd0);
        load_pkt(0, 4, 'h40, 1);
        plan_grants(1, 0);
        wait_done("t6_done", 200);
        if (len_log.size() == 1) check("t6_len", 32'(len_log[0]), 32'd4);
        else check("t6_len_count", 32'(len_log.size()), 32'd1);
        check("t6_wr_count", 32'(wr_cnt), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
